// File: rtl/alpha_tag_encoder.sv
// Base-26 lowercase tag encoder: iterative subtract-26 division, one step per cycle,
// with the finished tag presented both as a parallel bus and as an MSD-first character stream.
`timescale 1ns/1ps
module alpha_tag_encoder #(
  parameter int VAL_W      = 16,
  parameter int DIGITS     = 3,
  parameter int LEAD_BLANK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  use_cnt,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   tag,
  output logic                  ovf,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready,
  output logic [VAL_W-1:0]      cnt
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);
  localparam logic [VAL_W-1:0] BASE = VAL_W'(26);
  localparam logic [8*DIGITS-1:0] ALL_A = {DIGITS{8'h61}};

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

  state_t state, state_next;

  logic [VAL_W-1:0]    rem;
  logic [VAL_W-1:0]    q;
  logic [DW-1:0]       d;
  logic [DW-1:0]       e;
  logic [DW-1:0]       e_dec;
  logic [4:0]          digs [DIGITS];
  logic                lt26;
  logic [8*DIGITS-1:0] new_tag;

  assign lt26  = (rem < BASE);
  assign e_dec = e - 1'b1;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CONV;
      CONV: if (lt26 && (d == LAST)) state_next = EMIT;
      EMIT: if (!done && char_valid && char_ready && (e == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Render the final tag; the MSD is still in rem on the committing cycle.
  always_comb begin
    logic       seen;
    logic [4:0] dv;
    new_tag = '0;
    seen    = 1'b0;
    dv      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dv = (i == DIGITS - 1) ? rem[4:0] : digs[i];
      if (dv != 5'd0) seen = 1'b1;
      if ((LEAD_BLANK != 0) && (i > 0) && !seen)
        new_tag[8*i +: 8] = 8'h20;
      else
        new_tag[8*i +: 8] = 8'h61 + {3'b000, dv};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      q          <= '0;
      d          <= '0;
      e          <= '0;
      for (int i = 0; i < DIGITS; i++) digs[i] <= '0;
      cnt        <= '0;
      tag        <= ALL_A;
      ovf        <= 1'b0;
      done       <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem <= use_cnt ? cnt : value;
            q   <= '0;
            d   <= '0;
            ovf <= 1'b0;
            if (use_cnt) cnt <= cnt + 1'b1;
          end
        end
        CONV: begin
          if (!lt26) begin
            rem <= rem - BASE;
            q   <= q + 1'b1;
          end else begin
            digs[d] <= rem[4:0];
            rem     <= q;
            q       <= '0;
            if (d == LAST) begin
              // A leftover quotient means the operand did not fit in DIGITS characters.
              ovf  <= (q != '0);
              tag  <= new_tag;
              done <= 1'b1;
              e    <= LAST;
            end else begin
              d <= d + 1'b1;
            end
          end
        end
        EMIT: begin
          if (done) begin
            char_valid <= 1'b1;
            char_data  <= tag[{e, 3'b000} +: 8];
          end else if (char_valid && char_ready) begin
            if (e == '0) begin
              char_valid <= 1'b0;
            end else begin
              e         <= e_dec;
              char_data <= tag[{e_dec, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_tag_encoder.sv
// Randomized self-checking bench for alpha_tag_encoder; one instance with plain rendering
// and one with leading blanks share all inputs and are compared to an arithmetic model.
`timescale 1ns/1ps
module tb_alpha_tag_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        use_cnt;
  logic [15:0] value;
  logic        char_ready;

  logic        busy0, done0, ovf0, cv0;
  logic [23:0] tag0;
  logic [7:0]  cd0;
  logic [15:0] cnt0;
  logic        busy1, done1, ovf1, cv1;
  logic [23:0] tag1;
  logic [7:0]  cd1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;

  always #5 clk = ~clk;

  alpha_tag_encoder #(.VAL_W(16), .DIGITS(3), .LEAD_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .use_cnt(use_cnt), .value(value),
    .busy(busy0), .done(done0), .tag(tag0), .ovf(ovf0),
    .char_valid(cv0), .char_data(cd0), .char_ready(char_ready), .cnt(cnt0)
  );

  alpha_tag_encoder #(.VAL_W(16), .DIGITS(3), .LEAD_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .use_cnt(use_cnt), .value(value),
    .busy(busy1), .done(done1), .tag(tag1), .ovf(ovf1),
    .char_valid(cv1), .char_data(cd1), .char_ready(char_ready), .cnt(cnt1)
  );

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Tag from plain base-26 arithmetic on the operand modulo 26^3.
  function automatic logic [23:0] modelTag(input int v, input bit lb);
    int m;
    int pw;
    logic [23:0] t;
    m  = v % 17576;
    pw = 1;
    t  = '0;
    for (int i = 0; i < 3; i++) begin
      if (lb && i > 0 && (m / pw) == 0) t[8*i +: 8] = 8'h20;
      else                               t[8*i +: 8] = 8'(8'h61 + (m / pw) % 26);
      pw = pw * 26;
    end
    return t;
  endfunction

  function automatic int modelCycles(input int v);
    return 3 + v / 26 + v / 676 + v / 17576;
  endfunction

  task automatic checkReset(input string name);
    checkOutput({name, "_busy"}, busy0, 0);
    checkOutput({name, "_done"}, done0 | done1, 0);
    checkOutput({name, "_ovf"}, ovf0, 0);
    checkOutput({name, "_cv"}, cv0, 0);
    checkOutput({name, "_cd"}, cd0, 8'h00);
    checkOutput({name, "_cnt"}, cnt0, 0);
    checkOutput({name, "_tag0"}, tag0, 24'h616161);
    checkOutput({name, "_tag1"}, tag1, 24'h616161);
  endtask

  // mode 0: always ready, 1: random ready, 2: 5 low then 1,0,1,1
  task automatic applyStimulus(input int v, input bit uc, input int mode, input bit poke);
    int operand;
    int cyc;
    int got;
    int k;
    bit r;
    bit holding;
    logic [7:0] held;
    logic [23:0] e0, e1;
    int pat [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 1};
    operand = uc ? mcnt : v;
    e0 = modelTag(operand, 1'b0);
    e1 = modelTag(operand, 1'b1);
    @(negedge clk);
    value = 16'(v);
    use_cnt = uc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (uc) mcnt = (mcnt + 1) % 65536;
    checkOutput("busyAfterStart", busy0, 1);
    checkOutput("cntAfterStart", cnt0, 64'(mcnt));
    if (poke) begin
      start = 1'b1;
      use_cnt = 1'b1;
    end
    cyc = 0;
    while (!done0 && cyc < 5000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checkOutput("convCycles", 64'(cyc), 64'(modelCycles(operand)));
    if (poke) checkOutput("cntIgnored", cnt0, 64'(mcnt));
    checkOutput("done0", done0, 1);
    checkOutput("done1", done1, 1);
    checkOutput("tag0", tag0, e0);
    checkOutput("tag1", tag1, e1);
    checkOutput("ovf0", ovf0, operand >= 17576);
    checkOutput("ovf1", ovf1, operand >= 17576);
    checkOutput("validAtDone", cv0, 0);
    got = 0;
    k = 0;
    holding = 0;
    held = '0;
    while (got < 3 && k < 300) begin
      @(negedge clk);
      k++;
      if (k == 1) checkOutput("validAfterDone", cv0, 1);
      if (holding) begin
        checkOutput("holdValid", cv0, 1);
        checkOutput("holdData", cd0, held);
      end
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2:       r = (k <= 9) ? 1'(pat[k-1]) : 1'b1;
        default: r = 1'b1;
      endcase
      char_ready = r;
      if (cv0 && r) begin
        checkOutput("char0", cd0, e0[8*(2-got) +: 8]);
        checkOutput("char1", cd1, e1[8*(2-got) +: 8]);
        got++;
        holding = 0;
      end else if (cv0) begin
        holding = 1;
        held = cd0;
      end else begin
        holding = 0;
      end
    end
    if (got < 3) checkOutput("streamTimeout", 64'(got), 3);
    @(negedge clk);
    char_ready = 1'b0;
    checkOutput("validAfterLast", cv0, 0);
    checkOutput("busyAfterLast", busy0, 0);
  endtask

  task automatic resetMid(input int v, input bit inEmit);
    int k;
    @(negedge clk);
    value = 16'(v);
    use_cnt = 1'b0;
    start = 1'b1;
    char_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (inEmit) begin
      k = 0;
      while (!done0 && k < 5000) begin
        @(negedge clk);
        k++;
      end
      checkOutput("midDone", done0, 1);
      repeat (2) @(negedge clk);
      checkOutput("midEmitValid", cv0, 1);
    end else begin
      repeat (10) @(negedge clk);
      checkOutput("midConvBusy", busy0, 1);
    end
    rst = 1'b1;
    #1;
    checkReset(inEmit ? "rstEmit" : "rstConv");
    @(negedge clk);
    rst = 1'b0;
    mcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("noDoneAfterRst", done0, 0);
    end
    checkOutput("idleAfterRst", busy0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    use_cnt = 1'b0;
    value = '0;
    char_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    applyStimulus(0, 0, 0, 0);
    applyStimulus(27, 0, 2, 0);
    applyStimulus(17575, 0, 0, 0);
    applyStimulus(17576, 0, 1, 0);
    applyStimulus(26, 0, 0, 0);
    applyStimulus(676, 0, 1, 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mcnt = 0;
    applyStimulus(500, 1, 0, 0);
    applyStimulus(500, 1, 0, 1);
    applyStimulus(500, 1, 1, 0);
    checkOutput("cntThree", cnt0, 3);
    checkOutput("cntTagAac", tag0, 24'h616163);

    for (int i = 0; i < 14; i++)
      applyStimulus(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    resetMid(1000, 0);
    resetMid(1000, 1);
    applyStimulus(1000, 0, 0, 0);
    checkOutput("tagBmm", tag0, 24'h626d6d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alpha_tag_encoder.md
Name: alpha_tag_encoder

Overview:
- Sequential successor to the bench's two-letter transaction-ID helper.
- Converts an unsigned value into a DIGITS-character base-26 lowercase ASCII tag ('a'=0 … 'z'=25) using iterative subtract-26 division, one operation per cycle.
- Presents the tag as a parallel bus and as a valid/ready character stream (MSD first) for trace/log sinks.
- Lives in the verification utility layer; tags large-granularity transactions. Optional internal auto-incrementing transaction counter.

Parameters:
- VAL_W, 16: width of value input and internal counter.
- DIGITS, 3: tag length in characters (≥1).
- LEAD_BLANK, 0: 1 = render digits above the most significant non-zero digit as ' ' (0x20); digit 0 is always a letter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request conversion; accepted only in IDLE.
- use_cnt  in  1  sampled with accepted start: 1 = convert internal counter, 0 = convert value.
- value  in  VAL_W  operand when use_cnt=0.
- busy  out  1  high in CONV and EMIT.
- done  out  1  one-cycle pulse when tag becomes valid.
- tag  out  8*DIGITS  ASCII tag; byte DIGITS-1 (MSD) in top bits; held until next accepted start.
- ovf  out  1  operand ≥ 26^DIGITS (tag shows operand mod 26^DIGITS); held like tag.
- char_valid  out  1  stream character valid.
- char_data  out  8  stream character.
- char_ready  in  1  sink accepts character.
- cnt  out  VAL_W  current internal counter value.

Behaviour:
- Reset (async, any state): state IDLE; busy=0, done=0, ovf=0, char_valid=0, char_data=0x00, cnt=0; every byte of tag='a' (0x61).
- States: IDLE, CONV, EMIT.
- IDLE: on start:
  - latch rem = (use_cnt ? cnt : value), q=0, digit index d=0; clear ovf.
  - if use_cnt=1, cnt increments next edge, wrapping 2^VAL_W-1 -> 0.
  - go CONV.
  - start while busy is ignored; cnt is unchanged.
- CONV: exactly one action per cycle:
  - if rem ≥ 26: rem -= 26, q += 1.
  - else commit digit d = rem; rem <= q, q <= 0, d += 1.
  - after committing d = DIGITS-1: ovf <= (q != 0), i.e. residual quotient non-zero; apply LEAD_BLANK; tag updates; done pulses the same cycle tag is first visible; go EMIT.
  - CONV length = DIGITS + total subtractions. Examples: value 0 takes 3 cycles; value 27 takes 4 cycles.
  - Internal rem/q widths: VAL_W bits, no truncation.
- EMIT: streams DIGITS characters, MSD first (byte DIGITS-1 down to 0); blanks are included.
  - char_valid asserted the cycle after done.
  - A character transfers on a cycle with char_valid & char_ready.
  - char_data is stable while char_valid=1 and char_ready=0; char_valid never drops without a transfer.
  - Back-to-back transfers at one char/cycle when char_ready is held high.
  - After the digit-0 transfer: char_valid=0 the next cycle, state IDLE, busy=0. A start in that same cycle is accepted.
- LEAD_BLANK=1: positions d>0 where the committed digit and all higher digits are 0 render 0x20. Value 0 renders "  a".
- Reset mid-CONV/EMIT aborts immediately; no done pulse; partial tag discarded (tag returns to all 'a').
- done and ovf are never asserted together with a start acceptance in the same cycle.

Test Plan:
- Reset, start value=0, DIGITS=3, LEAD_BLANK=0 -> busy 3 CONV cycles; done; tag="aaa"; ovf=0; stream 'a','a','a'.
- start value=27 -> 4 CONV cycles, tag="abb"; value=17575 -> tag="zzz", ovf=0; value=17576 -> tag="aaa", ovf=1.
- LEAD_BLANK=1: value=0 -> "  a"; value=26 -> " ba"; value=676 -> "baa".
- Stream back-pressure, value=27: char_ready low 5 cycles -> char_data holds 'a', char_valid stays 1. Then ready pattern 1,0,1,1 -> order 'a','b','b' with no duplicates or drops; busy falls after the last transfer.
- use_cnt=1 three sequential starts from reset -> tags "aaa","aab","aac"; cnt=3. A start pulsed during busy is ignored and cnt is unchanged.
- Assert rst mid-CONV (value=1000) and mid-EMIT -> immediate IDLE, outputs at reset values, no done. A following start value=1000 -> tag="bmm".
